// File: rtl/prio_enc_seg_disp.sv
// rtl/prio_enc_seg_disp.sv - debounced priority encoder with seven-segment readout
// Define PRIO_ENC_SEG_DEC_EN for decimal digits; hex digits otherwise.
module prio_enc_seg_disp #(
  parameter int IN_W       = 16,
  parameter int DIGITS     = 2,
  parameter int DEB_CYCLES = 4,
  localparam int IDX_W     = $clog2(IN_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [IN_W-1:0]       sw,
  output logic [IN_W-1:0]       led,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid,
  output logic                  chg,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
`ifdef PRIO_ENC_SEG_DEC_EN
  localparam int unsigned BASE = 10;
`else
  localparam int unsigned BASE = 16;
`endif

  // Active-low segments, bit6..0 = a..g.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  logic [IN_W-1:0]     s1_q, s2_q, cand_q, acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IN_W-1:0]     led_q, led_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                chg_q, chg_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  int unsigned         rem;

  // Two-flop synchroniser, then a candidate must survive DEB_CYCLES more edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        acc_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    idx_d   = '0;
    valid_d = |acc_q;
    led_d   = en ? acc_q : '0;
    seg_d   = '1;
    rem     = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (acc_q[i]) idx_d = IDX_W'(i);
    end
    chg_d = ({valid_d, idx_d} != {valid_q, idx_q});
    // Repeated division wraps the value modulo BASE**DIGITS for free.
    if (en) begin
      rem = 32'(idx_d);
      for (int d = 0; d < DIGITS; d++) begin
        seg_d[7*d +: 7] = glyph(4'(rem % BASE));
        rem = rem / BASE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      seg_q   <= '1;
    end else begin
      led_q   <= led_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      seg_q   <= seg_d;
    end
  end

  assign led   = led_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign chg   = chg_q;
  assign seg   = seg_q;

endmodule
